// File: rtl/op_sram_arbiter.sv
// op_sram_arbiter: two-requester (host/corelet) arbiter for a single-port OP SRAM.
// Round-robin on ties, corelet burst lock, out-of-range addresses turned into err pulses.
module op_sram_arbiter #(
  parameter int DW    = 128,
  parameter int AW    = 9,
  parameter int DEPTH = 340
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_req,
  input  logic          host_wr,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_d,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic          host_err,
  input  logic          core_req,
  input  logic          core_wr,
  input  logic          core_lock,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_d,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic          core_err,
  output logic          sram_cen,
  output logic          sram_wen,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_d,
  input  logic [DW-1:0] sram_q,
  output logic [DW-1:0] rdata
);
  typedef enum logic [1:0] {IDLE, RR, CORE_LOCK} state_t;
  state_t        state_q, state_d;
  logic          last_core_q, last_core_d;
  logic [1:0]    rd_q, rd_d, err_q, err_d;
  logic          locked, in_range, acc, win_wr;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_d;
  // Bit 1 of rd/err tracks the corelet, bit 0 the host.
  always_comb begin
    locked      = (state_q == CORE_LOCK) & core_req & core_lock;
    host_gnt    = ~reset & ~locked & host_req & (~core_req | last_core_q);
    core_gnt    = ~reset & core_req & ~host_gnt;
    win_addr    = host_gnt ? host_addr : core_addr;
    win_wr      = host_gnt ? host_wr : core_wr;
    win_d       = host_gnt ? host_d : core_d;
    in_range    = {1'b0, win_addr} < (AW+1)'(DEPTH);
    acc         = (host_gnt | core_gnt) & in_range;
    sram_cen    = ~acc;
    sram_wen    = ~(acc & win_wr);
    sram_addr   = acc ? win_addr : '0;
    sram_d      = acc ? win_d : '0;
    rd_d        = {core_gnt & acc & ~win_wr, host_gnt & acc & ~win_wr};
    err_d       = {core_gnt & ~in_range, host_gnt & ~in_range};
    last_core_d = host_gnt ? 1'b0 : core_gnt ? 1'b1 : last_core_q;
    state_d     = ~(host_req | core_req) ? IDLE : (core_gnt & core_lock) ? CORE_LOCK : RR;
    host_rvalid = rd_q[0];
    core_rvalid = rd_q[1];
    host_err    = err_q[0];
    core_err    = err_q[1];
    rdata       = |rd_q ? sram_q : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_core_q <= 1'b1;
      rd_q        <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_core_q <= last_core_d;
      rd_q        <= rd_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_op_sram_arbiter.sv
// tb_op_sram_arbiter: vector table, directed corner sequences and random traffic vs a reference model.
module tb_op_sram_arbiter;
  localparam int DEPTH = 340;
  localparam logic [127:0] PA = {16{8'hA5}};
  localparam logic [127:0] PC = {16{8'h3C}};
  logic         clk = 1'b0, reset = 1'b1;
  logic         host_req = 0, host_wr = 0, core_req = 0, core_wr = 0, core_lock = 0;
  logic [8:0]   host_addr = '0, core_addr = '0;
  logic [127:0] host_d = '0, core_d = '0;
  logic         host_gnt, host_rvalid, host_err, core_gnt, core_rvalid, core_err;
  logic         sram_cen, sram_wen;
  logic [8:0]   sram_addr;
  logic [127:0] sram_d, rdata;
  logic [127:0] sram_q = '0;
  logic [127:0] mem [512] = '{default: '0};
  int tests = 0, fails = 0;

  op_sram_arbiter #(.DW(128), .AW(9), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr), .host_d(host_d),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_err(host_err),
    .core_req(core_req), .core_wr(core_wr), .core_lock(core_lock), .core_addr(core_addr),
    .core_d(core_d), .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_err(core_err),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_d(sram_d),
    .sram_q(sram_q), .rdata(rdata)
  );

  always #5 clk = ~clk;

  // SRAM stand-in: one-cycle registered read.
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen) mem[sram_addr] <= sram_d;
      else sram_q <= mem[sram_addr];
    end
  end

  typedef struct {
    logic gh, gc, cen, wen;
    logic [8:0] addr;
    logic [127:0] d;
    logic hrv, crv, herr, cerr;
    logic [127:0] rd;
  } exp_t;

  typedef struct {
    logic hr, hw;
    logic [8:0] ha;
    logic cr, cw, cl;
    logic [8:0] ca;
    logic rs;
    exp_t e;
  } vec_t;

  function automatic vec_t mk(input int hr, hw, ha, cr, cw, cl, ca, rs,
                              eh, ec, ecen, ewen, ea, hrv, crv, herr, cerr, rd8);
    vec_t v;
    v.hr = hr[0]; v.hw = hw[0]; v.ha = ha[8:0];
    v.cr = cr[0]; v.cw = cw[0]; v.cl = cl[0]; v.ca = ca[8:0]; v.rs = rs[0];
    v.e.gh = eh[0]; v.e.gc = ec[0]; v.e.cen = ecen[0]; v.e.wen = ewen[0]; v.e.addr = ea[8:0];
    v.e.d = ecen[0] ? '0 : (eh[0] ? PA : PC);
    v.e.hrv = hrv[0]; v.e.crv = crv[0]; v.e.herr = herr[0]; v.e.cerr = cerr[0];
    v.e.rd = {16{rd8[7:0]}};
    return v;
  endfunction

  task automatic cmp(input string n, input logic [127:0] a, input logic [127:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic check_all(input string t, input exp_t e);
    cmp({t, " host_gnt"}, 128'(host_gnt), 128'(e.gh));
    cmp({t, " core_gnt"}, 128'(core_gnt), 128'(e.gc));
    cmp({t, " sram_cen"}, 128'(sram_cen), 128'(e.cen));
    cmp({t, " sram_wen"}, 128'(sram_wen), 128'(e.wen));
    cmp({t, " sram_addr"}, 128'(sram_addr), 128'(e.addr));
    cmp({t, " sram_d"}, sram_d, e.d);
    cmp({t, " host_rvalid"}, 128'(host_rvalid), 128'(e.hrv));
    cmp({t, " core_rvalid"}, 128'(core_rvalid), 128'(e.crv));
    cmp({t, " host_err"}, 128'(host_err), 128'(e.herr));
    cmp({t, " core_err"}, 128'(core_err), 128'(e.cerr));
    cmp({t, " rdata"}, rdata, e.rd);
  endtask

  // Reference model: who was served last, whether a lock burst is open,
  // and what each requester is owed on the cycle after its grant.
  logic         m_last_core, m_lk, m_hrv, m_crv, m_herr, m_cerr;
  logic [127:0] m_rd;
  logic [127:0] ref_mem [512] = '{default: '0};
  logic         s_hg, s_cg, s_cen;

  task automatic model_reset();
    m_last_core = 1; m_lk = 0; m_hrv = 0; m_crv = 0; m_herr = 0; m_cerr = 0; m_rd = '0;
  endtask

  task automatic tick(input string t, output logic gh, output logic gc);
    exp_t e;
    logic inr, wr;
    logic [8:0] a;
    logic [127:0] d;
    if (m_lk && core_req && core_lock) begin
      gh = 0; gc = 1;
    end else begin
      gh = host_req && (!core_req || m_last_core);
      gc = core_req && !gh;
    end
    a = gh ? host_addr : core_addr;
    wr = gh ? host_wr : core_wr;
    d = gh ? host_d : core_d;
    inr = (gh || gc) && int'(a) < DEPTH;
    e.gh = gh; e.gc = gc; e.cen = !inr; e.wen = !(inr && wr);
    e.addr = inr ? a : '0; e.d = inr ? d : '0;
    e.hrv = m_hrv; e.crv = m_crv; e.herr = m_herr; e.cerr = m_cerr;
    e.rd = (m_hrv || m_crv) ? m_rd : '0;
    @(negedge clk);
    s_hg = host_gnt; s_cg = core_gnt; s_cen = sram_cen;
    check_all(t, e);
    m_hrv = gh && inr && !wr; m_crv = gc && inr && !wr;
    m_herr = gh && !inr; m_cerr = gc && !inr;
    if (inr) begin
      if (wr) ref_mem[a] = d;
      else m_rd = ref_mem[a];
    end
    if (gh) m_last_core = 0;
    else if (gc) m_last_core = 1;
    m_lk = gc && core_lock;
    @(posedge clk); #1;
  endtask

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [8:0] raddr();
    int r = $urandom_range(0, 9);
    if (r == 0) return 9'($urandom_range(DEPTH, 511));
    if (r == 1) return 9'(DEPTH - 1);
    return 9'($urandom_range(0, 15));
  endfunction

  initial begin
    vec_t tbl[13];
    exp_t z;
    logic gh, gc;
    z.gh = 0; z.gc = 0; z.cen = 1; z.wen = 1; z.addr = '0; z.d = '0;
    z.hrv = 0; z.crv = 0; z.herr = 0; z.cerr = 0; z.rd = '0;
    //             hr hw ha   cr cw cl ca  rs  eh ec cen wen addr hrv crv herr cerr rd
    tbl[0]  = mk(1, 1, 5,   0, 0, 0, 0,   0,  1, 0, 0, 0, 5,   0, 0, 0, 0, 'h00);
    tbl[1]  = mk(1, 0, 5,   1, 0, 0, 5,   1,  0, 0, 1, 1, 0,   0, 0, 0, 0, 'h00);
    tbl[2]  = mk(1, 0, 5,   1, 0, 0, 5,   0,  1, 0, 0, 1, 5,   0, 0, 0, 0, 'h00);
    tbl[3]  = mk(1, 0, 5,   1, 0, 0, 5,   0,  0, 1, 0, 1, 5,   1, 0, 0, 0, 'hA5);
    tbl[4]  = mk(1, 0, 5,   1, 0, 0, 5,   0,  1, 0, 0, 1, 5,   0, 1, 0, 0, 'hA5);
    tbl[5]  = mk(1, 0, 5,   1, 0, 0, 5,   0,  0, 1, 0, 1, 5,   1, 0, 0, 0, 'hA5);
    tbl[6]  = mk(0, 0, 0,   0, 0, 0, 0,   0,  0, 0, 1, 1, 0,   0, 1, 0, 0, 'hA5);
    tbl[7]  = mk(0, 0, 0,   1, 0, 0, 340, 0,  0, 1, 1, 1, 0,   0, 0, 0, 0, 'h00);
    tbl[8]  = mk(0, 0, 0,   1, 0, 0, 339, 0,  0, 1, 0, 1, 339, 0, 0, 0, 1, 'h00);
    tbl[9]  = mk(0, 0, 0,   0, 0, 0, 0,   0,  0, 0, 1, 1, 0,   0, 1, 0, 0, 'h00);
    tbl[10] = mk(1, 0, 400, 1, 1, 0, 7,   0,  1, 0, 1, 1, 0,   0, 0, 0, 0, 'h00);
    tbl[11] = mk(0, 0, 0,   1, 1, 0, 7,   0,  0, 1, 0, 0, 7,   0, 0, 1, 0, 'h00);
    tbl[12] = mk(0, 0, 0,   0, 0, 0, 0,   0,  0, 0, 1, 1, 0,   0, 0, 0, 0, 'h00);
    host_d = PA; core_d = PC;
    repeat (2) @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      reset = tbl[i].rs;
      host_req = tbl[i].hr; host_wr = tbl[i].hw; host_addr = tbl[i].ha;
      core_req = tbl[i].cr; core_wr = tbl[i].cw; core_lock = tbl[i].cl; core_addr = tbl[i].ca;
      @(negedge clk);
      check_all($sformatf("vec%0d", i), tbl[i].e);
      @(posedge clk); #1;
    end
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    ref_mem[5] = PA; ref_mem[7] = PC;
    // Lock burst: host takes the first slot so the corelet wins the opening tie.
    host_req = 1; host_wr = 1; host_addr = 20; host_d = r128();
    tick("lk_pre", gh, gc);
    host_wr = 0; host_addr = 21;
    core_req = 1; core_wr = 0; core_lock = 1; core_addr = 22;
    for (int k = 0; k < 6; k++) begin
      tick("lock", gh, gc);
      cmp("lock core_gnt", 128'(s_cg), 128'(1'b1));
      cmp("lock host_gnt", 128'(s_hg), 128'(1'b0));
    end
    core_lock = 0;
    tick("unlock", gh, gc);
    cmp("unlock host_gnt", 128'(s_hg), 128'(1'b1));
    host_req = 0; core_req = 0;
    tick("unlock_tail", gh, gc);
    // Reset landing between a read grant and its rvalid edge.
    host_req = 1; host_wr = 0; host_addr = 5;
    @(negedge clk);
    cmp("rst_rd host_gnt", 128'(host_gnt), 128'(1'b1));
    #2 reset = 1;
    #1 check_all("rst_force", z);
    @(posedge clk); #1;
    @(negedge clk);
    check_all("rst_hold", z);
    host_req = 0;
    reset = 0;
    model_reset();
    @(posedge clk); #1;
    host_req = 1;
    tick("resume", gh, gc);
    cmp("resume host_gnt", 128'(s_hg), 128'(1'b1));
    host_req = 0;
    tick("resume_rv", gh, gc);
    for (int k = 0; k < 10; k++) begin
      tick("idle", gh, gc);
      cmp("idle sram_cen", 128'(s_cen), 128'(1'b1));
    end
    gh = 1; gc = 1;
    for (int k = 0; k < 2000; k++) begin
      if (gh || !host_req) begin
        host_req = $urandom_range(0, 2) != 0;
        host_wr = 1'($urandom_range(0, 1));
        host_addr = raddr();
        host_d = r128();
      end
      if (gc || !core_req) begin
        core_req = $urandom_range(0, 2) != 0;
        core_wr = 1'($urandom_range(0, 1));
        core_addr = raddr();
        core_d = r128();
      end
      if ($urandom_range(0, 3) == 0) core_lock = !core_lock;
      tick("rnd", gh, gc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
